// File: rtl/disp_load_seq.sv
// Two-requester display loader: captures a 4-digit hex value plus decimal points
// and writes four active-low segment patterns into the display mux buffers.
// Optional leading-zero blanking is enabled by defining DISP_LZ_BLANK_EN.
module disp_load_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic [15:0] val0,
  input  logic [15:0] val1,
  input  logic [3:0]  dp0,
  input  logic [3:0]  dp1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        load,
  output logic [1:0]  bufdestino,
  output logic [7:0]  datai,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  state_t      state, state_nxt;
  logic [1:0]  cnt, cnt_nxt;
  logic [15:0] cap_val;
  logic [3:0]  cap_dp;
  logic        last;
  logic        pick0, pick1;
  logic [3:0]  nib;
  logic        blank;
  logic [7:0]  pat;

  // Tie goes to whichever requester was not served last.
  always_comb begin
    pick0 = req0 && (!req1 || last);
    pick1 = req1 && !pick0;
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE:  if (req0 || req1) begin
               state_nxt = WRITE;
               cnt_nxt   = 2'd0;
             end
      WRITE: begin
               cnt_nxt = cnt + 2'd1;
               if (cnt == 2'd3) state_nxt = DONE;
             end
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= 2'd0;
      cap_val <= 16'd0;
      cap_dp  <= 4'd0;
      last    <= 1'b1;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      gnt0  <= (state == IDLE) && pick0;
      gnt1  <= (state == IDLE) && pick1;
      if (state == IDLE && (pick0 || pick1)) begin
        cap_val <= pick0 ? val0 : val1;
        cap_dp  <= pick0 ? dp0  : dp1;
        last    <= pick1;
      end
    end
  end

  assign nib = cap_val[{cnt, 2'b00} +: 4];

`ifdef DISP_LZ_BLANK_EN
  always_comb begin
    case (cnt)
      2'd3:    blank = (cap_val[15:12] == 4'd0);
      2'd2:    blank = (cap_val[15:8]  == 8'd0);
      2'd1:    blank = (cap_val[15:4]  == 12'd0);
      default: blank = 1'b0;
    endcase
  end
`else
  assign blank = 1'b0;
`endif

  // Patterns carry bit0 = 1 (dp off); XOR with the dp enable lights it.
  always_comb begin
    case (nib)
      4'h0: pat = 8'h03;  4'h1: pat = 8'h9F;
      4'h2: pat = 8'h25;  4'h3: pat = 8'h0D;
      4'h4: pat = 8'h99;  4'h5: pat = 8'h49;
      4'h6: pat = 8'h41;  4'h7: pat = 8'h1F;
      4'h8: pat = 8'h01;  4'h9: pat = 8'h09;
      4'hA: pat = 8'h11;  4'hB: pat = 8'hC1;
      4'hC: pat = 8'h63;  4'hD: pat = 8'h85;
      4'hE: pat = 8'h61;  default: pat = 8'h71;
    endcase
    if (blank) pat = 8'hFF;
  end

  always_comb begin
    load       = (state == WRITE);
    busy       = (state != IDLE);
    done       = (state == DONE);
    bufdestino = load ? cnt : 2'd0;
    datai      = load ? (pat ^ {7'd0, cap_dp[cnt]}) : 8'd0;
  end

endmodule

// File: tb/tb_disp_load_seq.sv
// Directed bench for disp_load_seq: hand-computed segment writes, arbitration,
// busy masking, mid-write reset and leading-zero blanking.
module tb_disp_load_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [15:0] val0 = 16'd0, val1 = 16'd0;
  logic [3:0]  dp0 = 4'd0, dp1 = 4'd0;
  logic        gnt0, gnt1, load, busy, done;
  logic [1:0]  bufdestino;
  logic [7:0]  datai;

  int tests = 0;
  int fails = 0;

  always #10 clk = ~clk;

  disp_load_seq dut (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1),
    .val0(val0), .val1(val1), .dp0(dp0), .dp1(dp1),
    .gnt0(gnt0), .gnt1(gnt1), .load(load), .bufdestino(bufdestino),
    .datai(datai), .busy(busy), .done(done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic chk_wr(input string tag, input logic [1:0] b, input logic [7:0] d);
    chk({tag, ".load"}, 16'(load), 16'd1);
    chk({tag, ".buf"},  16'(bufdestino), 16'(b));
    chk({tag, ".data"}, 16'(datai), 16'(d));
  endtask

  task automatic chk_gnt(input string tag, input logic g0, input logic g1);
    chk({tag, ".gnt0"}, 16'(gnt0), 16'(g0));
    chk({tag, ".gnt1"}, 16'(gnt1), 16'(g1));
  endtask

  task automatic chk_quiet(input string tag, input logic b, input logic d);
    chk({tag, ".load"}, 16'(load), 16'd0);
    chk({tag, ".data"}, 16'(datai), 16'd0);
    chk({tag, ".buf"},  16'(bufdestino), 16'd0);
    chk({tag, ".busy"}, 16'(busy), 16'(b));
    chk({tag, ".done"}, 16'(done), 16'(d));
  endtask

  initial begin
    logic [7:0] lz1, lz2, lz3, fd3;
`ifdef DISP_LZ_BLANK_EN
    lz1 = 8'hFF; lz2 = 8'hFF; lz3 = 8'hFF; fd3 = 8'hFE;
`else
    lz1 = 8'h03; lz2 = 8'h03; lz3 = 8'h03; fd3 = 8'h02;
`endif

    // reset state
    tick(); tick();
    chk_quiet("rst", 1'b0, 1'b0);
    chk_gnt("rst", 1'b0, 1'b0);
    reset = 1'b0;

    // single requester, value 0x1234
    req0 = 1'b1; val0 = 16'h1234; dp0 = 4'h0;
    tick();
    chk_gnt("t1.g", 1'b1, 1'b0);
    chk("t1.busy", 16'(busy), 16'd1);
    chk_wr("t1.d0", 2'd0, 8'h99);
    req0 = 1'b0;
    tick(); chk_gnt("t1.g2", 1'b0, 1'b0); chk_wr("t1.d1", 2'd1, 8'h0D);
    tick(); chk_wr("t1.d2", 2'd2, 8'h25);
    tick(); chk_wr("t1.d3", 2'd3, 8'h9F);
    tick(); chk_quiet("t1.done", 1'b1, 1'b1);
    tick(); chk_quiet("t1.idle", 1'b0, 1'b0);

    // tie after reset: req0 first, req1 waits; val0 changes mid-write
    reset = 1'b1; tick(); reset = 1'b0;
    req0 = 1'b1; req1 = 1'b1; val0 = 16'h1234; val1 = 16'hABCD; dp1 = 4'h0;
    tick();
    chk_gnt("t2.g", 1'b1, 1'b0);
    chk_wr("t2.d0", 2'd0, 8'h99);
    req0 = 1'b0; val0 = 16'hFFFF; dp0 = 4'hF;
    tick(); chk_gnt("t2.w1", 1'b0, 1'b0); chk("t2.busy1", 16'(busy), 16'd1); chk_wr("t2.d1", 2'd1, 8'h0D);
    tick(); chk_gnt("t2.w2", 1'b0, 1'b0); chk_wr("t2.d2", 2'd2, 8'h25);
    tick(); chk_gnt("t2.w3", 1'b0, 1'b0); chk_wr("t2.d3", 2'd3, 8'h9F);
    tick(); chk_gnt("t2.w4", 1'b0, 1'b0); chk_quiet("t2.done", 1'b1, 1'b1);
    tick(); chk_gnt("t2.w5", 1'b0, 1'b0); chk_quiet("t2.idle", 1'b0, 1'b0);
    tick();
    chk_gnt("t2.g1", 1'b0, 1'b1);
    chk_wr("t2.e0", 2'd0, 8'h85);
    req1 = 1'b0;
    tick(); chk_wr("t2.e1", 2'd1, 8'h63);
    tick(); chk_wr("t2.e2", 2'd2, 8'hC1);
    tick(); chk_wr("t2.e3", 2'd3, 8'h11);
    tick(); chk_quiet("t2.done2", 1'b1, 1'b1);
    tick(); chk_quiet("t2.idle2", 1'b0, 1'b0);

    // leading zeros with dp on digit 0; a short req1 while busy is dropped
    req0 = 1'b1; val0 = 16'h0008; dp0 = 4'b0001;
    tick();
    chk_gnt("t3.g", 1'b1, 1'b0);
    chk_wr("t3.d0", 2'd0, 8'h00);
    req0 = 1'b0; req1 = 1'b1;
    tick(); chk_wr("t3.d1", 2'd1, lz1);
    req1 = 1'b0;
    tick(); chk_wr("t3.d2", 2'd2, lz2);
    tick(); chk_wr("t3.d3", 2'd3, lz3);
    tick(); chk_quiet("t3.done", 1'b1, 1'b1);
    tick(); chk_quiet("t3.idle", 1'b0, 1'b0); chk_gnt("t3.ng0", 1'b0, 1'b0);
    tick(); chk_quiet("t3.idle2", 1'b0, 1'b0); chk_gnt("t3.ng1", 1'b0, 1'b0);

    // reset mid-write, then tie resolves to requester 0 again
    req0 = 1'b1; val0 = 16'h1234; dp0 = 4'h0;
    val1 = 16'h0F00; dp1 = 4'b1010;
    tick();
    chk_gnt("t4.g", 1'b1, 1'b0);
    chk_wr("t4.d0", 2'd0, 8'h99);
    req1 = 1'b1;
    tick(); chk_wr("t4.d1", 2'd1, 8'h0D);
    reset = 1'b1;
    tick();
    chk_quiet("t4.rst", 1'b0, 1'b0);
    chk_gnt("t4.rstg", 1'b0, 1'b0);
    reset = 1'b0;
    tick();
    chk_gnt("t4.tie", 1'b1, 1'b0);
    chk_wr("t4.r0", 2'd0, 8'h99);
    req0 = 1'b0;
    tick(); chk_wr("t4.r1", 2'd1, 8'h0D);
    tick(); chk_wr("t4.r2", 2'd2, 8'h25);
    tick(); chk_wr("t4.r3", 2'd3, 8'h9F);
    tick(); chk_quiet("t4.done", 1'b1, 1'b1);
    tick(); chk_quiet("t4.idle", 1'b0, 1'b0);

    // requester 1 with a blanked top digit whose dp is lit
    tick();
    chk_gnt("t5.g", 1'b0, 1'b1);
    chk_wr("t5.d0", 2'd0, 8'h03);
    req1 = 1'b0;
    tick(); chk_wr("t5.d1", 2'd1, 8'h02);
    tick(); chk_wr("t5.d2", 2'd2, 8'h71);
    tick(); chk_wr("t5.d3", 2'd3, fd3);
    tick(); chk_quiet("t5.done", 1'b1, 1'b1);
    tick(); chk_quiet("t5.idle", 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/disp_load_seq.md
DISP_LOAD_SEQ -- requirements
Module: disp_load_seq

Interface
REQ-001 The block SHALL have no parameters; all behaviour is fixed or selected by the Configuration macro.
REQ-002 clk  input  1  system clock (50 MHz); all state changes on its rising edge.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 req0 / req1  input  1 each  display-update request from requester 0 / 1; held high until the matching grant.
REQ-005 val0 / val1  input  16 each  hex value of requester 0 / 1; nibble k is shown on digit k; held stable while the matching req is high.
REQ-006 dp0 / dp1  input  4 each  decimal-point enables of requester 0 / 1; bit k lights the dp of digit k.
REQ-007 gnt0 / gnt1  output  1 each  one-cycle pulse: value and dp of requester 0 / 1 captured.
REQ-008 load  output  1  buffer write strobe to the display mux.
REQ-009 bufdestino  output  2  destination buffer index for the write.
REQ-010 datai  output  8  segment pattern, active-low: bits [7:1] = segments a..g, bit [0] = dp.
REQ-011 busy  output  1  high whenever the state is not IDLE.
REQ-012 done  output  1  one-cycle pulse when all four buffers are written.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, WRITE and DONE, with a 2-bit digit counter used in WRITE.
REQ-014 In IDLE with req0 or req1 high at edge T, the block SHALL capture the winner's val/dp, enter WRITE and pulse that requester's gnt in cycle T+1.
REQ-015 Arbitration SHALL be round-robin: a sole requester wins; if both request, the requester not granted most recently wins.
REQ-016 In WRITE, load SHALL be 1 for exactly 4 consecutive cycles (T+1..T+4), with bufdestino = 0, 1, 2, 3 in that order.
REQ-017 In each WRITE cycle, datai SHALL be the encoding of captured nibble bufdestino with bit 0 = NOT dp[bufdestino].
REQ-018 Hex encodings for datai[7:1] plus dp off SHALL be: 0→0x03, 1→0x9F, 2→0x25, 3→0x0D, 4→0x99, 5→0x49, 6→0x41, 7→0x1F, 8→0x01, 9→0x09, A→0x11, b→0xC1, C→0x63, d→0x85, E→0x61, F→0x71.
REQ-019 DONE SHALL last one cycle (T+5) with done=1 and load=0, then return to IDLE; the earliest next capture is at the edge ending cycle T+6.
REQ-020 Outside WRITE, load SHALL be 0 and datai and bufdestino SHALL be 0.
REQ-021 Requests arriving while busy SHALL NOT be captured or granted; they wait until IDLE.
REQ-022 A req dropped before capture SHALL produce no grant and no write.
REQ-023 Changes to val/dp after capture SHALL NOT affect the transaction in progress.
REQ-024 At most one gnt SHALL be high in any cycle, and gnt0 and gnt1 SHALL never both be high.

Reset
REQ-025 On reset, the block SHALL enter IDLE and clear the digit counter, the captured data and all outputs.
REQ-026 On reset, the round-robin pointer SHALL be set to "last granted = 1", so requester 0 wins the first tie.
REQ-027 Reset asserted mid-WRITE SHALL force load=0 from the next cycle, with no done pulse; buffers already written are left as they are.

Configuration
REQ-028 The macro DISP_LZ_BLANK_EN SHALL select leading-zero blanking.
REQ-029 With DISP_LZ_BLANK_EN defined, digits 3, 2 and 1 SHALL be written as datai[7:1]=0x7F (blank) when the digit and all higher digits are zero.
REQ-030 With DISP_LZ_BLANK_EN defined, dp on a blanked digit SHALL still follow dp, and digit 0 SHALL never be blanked.
REQ-031 Without DISP_LZ_BLANK_EN, all four digits SHALL always be encoded per REQ-018.

Verification
REQ-032 Reset, then req0=1, val0=0x1234, dp0=0 → gnt0 in T+1; writes (0,0x99),(1,0x0D),(2,0x25),(3,0x9F) in T+1..T+4; done at T+5.
REQ-033 req0 and req1 high in the same cycle after reset, val1=0xABCD → requester 0 served first; requester 1 is granted at T+6 and writes 0x85,0x63,0xC1,0x11.
REQ-034 val0=0x0008, dp0=4'b0001 → with DISP_LZ_BLANK_EN: 0x00,0xFF,0xFF,0xFF; without: 0x00,0x03,0x03,0x03.
REQ-035 req1 held high through a whole req0 transaction, changing val0 during WRITE → outputs unaffected, no grant to requester 1 before T+6, busy high T+1..T+5.
REQ-036 reset asserted at T+2 → load=0 from T+3, no done pulse, busy=0; the next tie goes to requester 0.
